// File: rtl/report_pkg.sv
// Shared definitions for the report collector.
// Contents:
//   state_e     - collector FSM states (stream, drain, done)
//   rec_width() - width of one FIFO record {offset, report bits}
package report_pkg;

    typedef enum logic [1:0] {
        StStream = 2'd0,
        StDrain  = 2'd1,
        StDone   = 2'd2
    } state_e;

    // Record layout is {offset, report_bits}; offset occupies the upper bits.
    function automatic int unsigned rec_width(input int unsigned offset_w,
                                              input int unsigned n_reports);
        return offset_w + n_reports;
    endfunction

endpackage

// File: rtl/report_fifo.sv
// Synchronous first-word-fall-through FIFO holding report records.
// Ports:
//   clk, reset       - clock and synchronous active-high reset
//   push, push_data  - write request and record; a push while full is accepted
//                      only when a pop happens in the same cycle
//   pop              - remove the head record (ignored when empty)
//   head             - current head record, valid whenever empty=0
//   count            - number of stored records
//   empty, full      - occupancy flags
module report_fifo #(
    parameter int unsigned WIDTH = 40,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             wr_en;
    logic             rd_en;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign head  = mem[rd_ptr_q];

    // When full, the slot being written is the one the pop frees this cycle.
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr_q] <= push_data;
                wr_ptr_q      <= wr_ptr_q + AW'(1);
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(wr_en) - CW'(rd_en);
        end
    end

endmodule

// File: rtl/report_collector.sv
// Collects automaton report vectors into a FIFO tagged with symbol offsets.
// Ports:
//   clk, reset             - clock and synchronous active-high reset
//   run, last_symbol       - symbol strobe and end-of-stream qualifier
//   report_bits            - active_state of the reporting STEs for this symbol
//   rpt_valid, rpt_ready   - record handshake (FWFT head of the FIFO)
//   rpt_offset, rpt_vector - symbol offset and report bits of the head record
//   rpt_last               - head is the final record of the stream
//   overflow               - sticky: at least one record was dropped
//   done                   - stream ended and every record has been delivered
module report_collector
    import report_pkg::*;
#(
    parameter int unsigned N_REPORTS = 8,
    parameter int unsigned OFFSET_W  = 32,
    parameter int unsigned DEPTH     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic                 last_symbol,
    input  logic [N_REPORTS-1:0] report_bits,
    output logic                 rpt_valid,
    input  logic                 rpt_ready,
    output logic [OFFSET_W-1:0]  rpt_offset,
    output logic [N_REPORTS-1:0] rpt_vector,
    output logic                 rpt_last,
    output logic                 overflow,
    output logic                 done
);

    localparam int unsigned REC_W = rec_width(OFFSET_W, N_REPORTS);
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    state_e              state_q;
    logic [OFFSET_W-1:0] offset_q;
    logic                overflow_q;

    logic                accept_sym;
    logic                push;
    logic                pop;
    logic [REC_W-1:0]    head;
    logic [CW-1:0]       fifo_count;
    logic                fifo_empty;
    logic                fifo_full;

    // Symbols only count while streaming; drain/done ignore the input side.
    assign accept_sym = run && (state_q == StStream);
    assign push       = accept_sym && (report_bits != '0);
    assign pop        = rpt_valid && rpt_ready;

    report_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({offset_q, report_bits}),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign rpt_valid  = !fifo_empty;
    assign rpt_offset = head[REC_W-1:N_REPORTS];
    assign rpt_vector = head[N_REPORTS-1:0];
    assign rpt_last   = (state_q == StDrain) && rpt_valid && (fifo_count == CW'(1));
    assign overflow   = overflow_q;
    assign done       = (state_q == StDone);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StStream;
            offset_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (accept_sym) begin
                offset_q <= offset_q + OFFSET_W'(1);
            end
            if (push && fifo_full && !pop) begin
                overflow_q <= 1'b1;
            end
            unique case (state_q)
                StStream: begin
                    if (accept_sym && last_symbol) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    // Finish as soon as the final record leaves, so done follows its pop.
                    if (fifo_empty || (pop && fifo_count == CW'(1))) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StDone;
                end
                default: begin
                    state_q <= StStream;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_report_collector.sv
// Self-checking bench for report_collector (small FIFO and offset counter so that
// overflow and wrap-around are reachable quickly).
module tb_report_collector;

    localparam int unsigned NR = 8;
    localparam int unsigned OW = 4;
    localparam int unsigned DP = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          run = 1'b0;
    logic          last_symbol = 1'b0;
    logic [NR-1:0] report_bits = '0;
    logic          rpt_valid;
    logic          rpt_ready = 1'b0;
    logic [OW-1:0] rpt_offset;
    logic [NR-1:0] rpt_vector;
    logic          rpt_last;
    logic          overflow;
    logic          done;

    int tests = 0;
    int fails = 0;

    // Reference model: records as {offset, bits} in a queue plus stream flags.
    logic [OW+NR-1:0] q[$];
    int               off_m;
    bit               ended_m;
    bit               done_m;
    bit               ovf_m;

    always #5 clk = ~clk;

    report_collector #(
        .N_REPORTS (NR),
        .OFFSET_W  (OW),
        .DEPTH     (DP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .last_symbol (last_symbol),
        .report_bits (report_bits),
        .rpt_valid   (rpt_valid),
        .rpt_ready   (rpt_ready),
        .rpt_offset  (rpt_offset),
        .rpt_vector  (rpt_vector),
        .rpt_last    (rpt_last),
        .overflow    (overflow),
        .done        (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        bit exp_valid;
        exp_valid = (q.size() != 0);
        chk({tag, ".valid"}, 32'(rpt_valid), 32'(exp_valid));
        if (exp_valid) begin
            chk({tag, ".offset"}, 32'(rpt_offset), 32'(q[0][OW+NR-1:NR]));
            chk({tag, ".vector"}, 32'(rpt_vector), 32'(q[0][NR-1:0]));
        end
        chk({tag, ".last"}, 32'(rpt_last), 32'(ended_m && !done_m && q.size() == 1));
        chk({tag, ".overflow"}, 32'(overflow), 32'(ovf_m));
        chk({tag, ".done"}, 32'(done), 32'(done_m));
    endtask

    // One clock: drive inputs, advance the model at the edge, check at negedge.
    task automatic tick(input string tag, input bit r, input bit l, input logic [NR-1:0] b,
                        input bit rdy);
        bit pop;
        bit was_ended;
        run         = r;
        last_symbol = l;
        report_bits = b;
        rpt_ready   = rdy;
        @(posedge clk);
        pop       = (q.size() != 0) && rdy;
        was_ended = ended_m;
        if (!ended_m && r) begin
            if (b != 0) begin
                if (q.size() < DP || pop) q.push_back({OW'(off_m % (1 << OW)), b});
                else ovf_m = 1;
            end
            off_m++;
            if (l) ended_m = 1;
        end
        if (pop) void'(q.pop_front());
        if (was_ended && q.size() == 0) done_m = 1;
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        run   = 1'b0;
        @(posedge clk);
        q.delete();
        off_m   = 0;
        ended_m = 0;
        done_m  = 0;
        ovf_m   = 0;
        @(negedge clk);
        reset = 1'b0;
        check_outputs(tag);
    endtask

    initial begin
        @(negedge clk);
        do_reset("reset0");

        // Single report at symbol 2, visible the cycle after its push.
        for (int i = 0; i < 5; i++) begin
            tick("single", 1, 0, (i == 2) ? 8'h01 : 8'h00, (i != 2));
            if (i == 2) begin
                chk("single.valid_t1", 32'(rpt_valid), 32'd1);
                chk("single.off2", 32'(rpt_offset), 32'd2);
                chk("single.vec01", 32'(rpt_vector), 32'h01);
            end
        end

        // Overflow: 6 reports into a 4-deep FIFO with no consumer.
        do_reset("reset1");
        for (int i = 0; i < 6; i++) tick("ovf.fill", 1, 0, 8'(i + 1), 0);
        chk("ovf.sticky", 32'(overflow), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("ovf.drain_off", 32'(rpt_offset), 32'(i));
            tick("ovf.drain", 0, 0, 8'h00, 1);
        end
        chk("ovf.empty", 32'(rpt_valid), 32'd0);

        // Full FIFO with a simultaneous pop accepts the new record.
        do_reset("reset2");
        for (int i = 0; i < 4; i++) tick("full.fill", 1, 0, 8'h10, 0);
        tick("full.pushpop", 1, 0, 8'h20, 1);
        chk("full.no_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 4; i++) tick("full.drain", 0, 0, 8'h00, 1);

        // Final record at offset 9 with a toggling consumer, then ignored input.
        do_reset("reset3");
        for (int i = 0; i < 10; i++)
            tick("last.stream", 1, (i == 9), (i == 3) ? 8'h04 : ((i == 9) ? 8'h80 : 8'h00),
                 i[0]);
        for (int i = 0; i < 8; i++) tick("last.drain", 0, 0, 8'h00, i[0]);
        chk("last.done", 32'(done), 32'd1);
        for (int i = 0; i < 3; i++) tick("last.ignored", 1, 0, 8'hff, 0);

        // Offset wrap with a 4-bit counter.
        do_reset("reset4");
        for (int i = 0; i < 18; i++)
            tick("wrap", 1, 0, (i == 15 || i == 16) ? 8'h03 : 8'h00, 0);
        chk("wrap.off15", 32'(rpt_offset), 32'd15);
        tick("wrap.pop", 0, 0, 8'h00, 1);
        chk("wrap.off0", 32'(rpt_offset), 32'd0);

        // Reset while draining with three records queued.
        do_reset("reset5");
        for (int i = 0; i < 3; i++) tick("rdrain.fill", 1, (i == 2), 8'h05, 0);
        tick("rdrain.hold", 0, 0, 8'h00, 0);
        do_reset("rdrain.reset");
        tick("rdrain.first", 1, 0, 8'h09, 0);
        chk("rdrain.off0", 32'(rpt_offset), 32'd0);

        // Zero-report stream goes straight through drain.
        do_reset("reset6");
        tick("zero.last", 1, 1, 8'h00, 1);
        tick("zero.done", 0, 0, 8'h00, 1);
        chk("zero.done_now", 32'(done), 32'd1);

        // Randomized streams against the model.
        for (int s = 0; s < 20; s++) begin
            int len;
            do_reset("rand.reset");
            len = $urandom_range(30, 3);
            for (int i = 0; i < len; i++)
                tick("rand.stream", $urandom_range(3, 0) != 0, (i == len - 1),
                     ($urandom_range(1, 0) != 0) ? 8'($urandom) : 8'h00,
                     $urandom_range(1, 0) != 0);
            // The final symbol must actually be presented to end the stream.
            tick("rand.end", 1, 1, 8'($urandom), $urandom_range(1, 0) != 0);
            for (int i = 0; i < 40 && !done_m; i++)
                tick("rand.drain", $urandom_range(1, 0) != 0, 0, 8'($urandom),
                     $urandom_range(2, 0) != 0);
            chk("rand.done", 32'(done), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/report_collector.md
REPORT_COLLECTOR -- requirements
Module: report_collector

Interface
REQ-001 SHALL have parameter N_REPORTS, default 8, meaning the number of reporting STE active_state bits collected.
REQ-002 SHALL have parameter OFFSET_W, default 32, meaning the symbol-offset counter width.
REQ-003 SHALL have parameter DEPTH, default 16, meaning the report FIFO entries (power of 2, at least 2).
REQ-004 SHALL have ports: clk  input  1  single clock, all logic on posedge.
REQ-005 SHALL have ports: reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports: run  input  1  a symbol is presented to the automaton this cycle.
REQ-007 SHALL have ports: last_symbol  input  1  qualifies the final symbol of the stream (valid only with run).
REQ-008 SHALL have ports: report_bits  input  N_REPORTS  active_state of the reporting STEs, same cycle as run.
REQ-009 SHALL have ports: rpt_valid  output  1  a report record is available.
REQ-010 SHALL have ports: rpt_ready  input  1  consumer accepts the record.
REQ-011 SHALL have ports: rpt_offset  output  OFFSET_W  symbol offset of the record.
REQ-012 SHALL have ports: rpt_vector  output  N_REPORTS  report bits of the record.
REQ-013 SHALL have ports: rpt_last  output  1  the record is the final record of the stream.
REQ-014 SHALL have ports: overflow  output  1  sticky flag, at least one record dropped.
REQ-015 SHALL have ports: done  output  1  stream ended and all records delivered.

Function
REQ-016 SHALL keep the offset counter: it increments by 1 on each cycle with run=1 in STREAM, wraps modulo 2^OFFSET_W, and tags each record with its pre-increment value (first symbol = 0).
REQ-017 SHALL push {offset, report_bits} when run=1, STREAM, and report_bits is nonzero; all-zero report_bits never push.
REQ-018 SHALL present the FIFO head first-word-fall-through; a record pushed in cycle t appears on outputs with rpt_valid=1 in cycle t+1.
REQ-019 SHALL define rpt_valid as FIFO not empty; pop on rpt_valid && rpt_ready; outputs SHALL hold stable while rpt_valid=1 and rpt_ready=0.
REQ-020 SHALL, on a push while full with no pop that cycle, drop the record and set overflow, which stays 1 until reset.
REQ-021 SHALL, on a push while full with a pop in the same cycle, accept the push with no overflow; push and pop on a non-full, non-empty FIFO leave the count unchanged.
REQ-022 SHALL implement an FSM with states STREAM, DRAIN and DONE:
- STREAM → DRAIN on run && last_symbol; that symbol's report is still pushed.
- DRAIN → DONE when the FIFO is empty.
- DONE holds until reset.
REQ-023 SHALL ignore run, last_symbol and report_bits in DRAIN and DONE: no push, no count.
REQ-024 SHALL drive rpt_last=1 only when the state is DRAIN, rpt_valid=1 and the FIFO count is 1.
REQ-025 SHALL drive done=1 exactly in DONE; a stream with zero reports reaches DONE one cycle after DRAIN entry, with no rpt_last ever asserted.

Reset
REQ-026 SHALL, on reset=1 at a clock edge (including mid-stream or mid-drain), return to STREAM, empty the FIFO and clear the offset counter, overflow and done.
REQ-027 SHALL drive rpt_valid=0, rpt_last=0, overflow=0 and done=0 in the cycle after reset; rpt_offset and rpt_vector are don't-care while rpt_valid=0.

Structure
REQ-028 SHALL place the FSM state encodings and the record width (OFFSET_W+N_REPORTS) helper constant in shared package report_pkg.
REQ-029 SHALL implement the storage as sub-module report_fifo, a synchronous FWFT FIFO with count output; the FSM and counter live in report_collector.

Verification
REQ-030 SHALL verify: 5 run cycles, report_bits=0x01 at symbol 2, rpt_ready=1 → one record offset=2 vector=0x01, one cycle after push.
REQ-031 SHALL verify: DEPTH=4, rpt_ready=0, 6 consecutive reporting symbols → 4 records (offsets 0-3) retained, overflow=1, later drain yields exactly those 4.
REQ-032 SHALL verify: full FIFO with rpt_ready=1 and a reporting symbol in the same cycle → record accepted, overflow stays 0.
REQ-033 SHALL verify: last_symbol with report 0x80 at offset 9, rpt_ready toggling → final record has rpt_last=1, done=1 the cycle after its pop, and later run is ignored.
REQ-034 SHALL verify: OFFSET_W=4, 18 run cycles reporting at symbols 15 and 16 → offsets 15 then 0.
REQ-035 SHALL verify: reset asserted in DRAIN with 3 records queued → next cycle rpt_valid=0, done=0, and the next reporting symbol has offset 0.
